fpu_arbiter: RTL and testbench

Shares one free-running `fpu` add/subtract datapath between `N_REQ` requesters. Each request is accepted over a valid/ready handshake. The block drives the accepted operands onto the FPU and holds them stable long enough for one complete FPU pass. It then captures `data_out`/`status_out` and returns them on a shared response channel tagged with the requester index. It sits between the requesting units and the single `fpu` instance and is the only driver of that instance's operand inputs.

---
 rtl/fpu_arbiter_if.sv | 27 ++
 rtl/fpu_arbiter.sv | 138 +++++++++++++
 tb/tb_fpu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_arbiter_if.sv
// Request/response channel bundle between the requesting units and fpu_arbiter.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface fpu_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_op_a;
  logic [32*N_REQ-1:0] req_op_b;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [31:0]         resp_data;
  logic [3:0]          resp_status;

  modport master (
    output req_valid, req_op_a, req_op_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_status
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_status
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Shares one free-running fpu add/sub datapath between N_REQ requesters, one transaction at a time.
// Define FPU_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module fpu_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FPU_CYCLES = 5
) (
  input  logic         clock100KHz,
  input  logic         reset,
  fpu_arbiter_if.slave bus,
  output logic [31:0]  fpu_op_a,
  output logic [31:0]  fpu_op_b,
  input  logic [31:0]  fpu_data_in,
  input  logic [3:0]   fpu_status_in,
  output logic         busy
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD  = 2 * FPU_CYCLES + 1;
  localparam int CNT_W = $clog2(HOLD);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ID_W-1:0]   id_reg;
  logic [31:0]       op_a_reg, op_b_reg, data_reg;
  logic [3:0]        status_reg;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic              load, capture;

`ifdef FPU_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] ptr_reg;

  // Pointer moves past the requester just served, so it gets lowest priority next round.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (state_reg == RESP && bus.resp_ready) begin
      if (int'(id_reg) == N_REQ - 1) ptr_reg <= '0;
      else                           ptr_reg <= id_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;
`endif

  // Scan downward so the candidate closest above the pointer is the last one written.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_W-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = reset && (state_reg == IDLE) && grant_found
                                 && (grant_idx == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          load       = 1'b1;
          cnt_next   = CNT_W'(HOLD - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are sampled only at the handshake and held until the next one.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      id_reg     <= '0;
      data_reg   <= '0;
      status_reg <= '0;
    end else begin
      if (load) begin
        op_a_reg <= bus.req_op_a[32*grant_idx +: 32];
        op_b_reg <= bus.req_op_b[32*grant_idx +: 32];
        id_reg   <= grant_idx;
      end
      if (capture) begin
        data_reg   <= fpu_data_in;
        status_reg <= fpu_status_in;
      end
    end
  end

  assign fpu_op_a        = op_a_reg;
  assign fpu_op_b        = op_b_reg;
  assign bus.resp_valid  = (state_reg == RESP);
  assign bus.resp_id     = id_reg;
  assign bus.resp_data   = data_reg;
  assign bus.resp_status = status_reg;
  assign busy            = (state_reg != IDLE);
endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a stand-in 5-stage FPU model on the operand bus.
module tb_fpu_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_data_in;
  logic [3:0]  fpu_status_in;
  logic        busy;

  fpu_arbiter_if #(.N_REQ(N)) bus ();

  fpu_arbiter #(.N_REQ(N), .FPU_CYCLES(5)) dut (
    .clock100KHz  (clk),
    .reset        (rst_n),
    .bus          (bus.slave),
    .fpu_op_a     (fpu_op_a),
    .fpu_op_b     (fpu_op_b),
    .fpu_data_in  (fpu_data_in),
    .fpu_status_in(fpu_status_in),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_data(input logic [31:0] a, input logic [31:0] b);
    return a + {b[15:0], b[31:16]};
  endfunction

  function automatic logic [3:0] model_status(input logic [31:0] a, input logic [31:0] b);
    return {2'b00, a[0] ^ b[31], ^(a ^ b)};
  endfunction

  // Stand-in FPU: result reflects operands seen five cycles earlier.
  logic [63:0] pipe [5];
  always @(posedge clk) begin
    pipe[0] <= {fpu_op_a, fpu_op_b};
    for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
  end
  assign fpu_data_in   = model_data(pipe[4][63:32], pipe[4][31:0]);
  assign fpu_status_in = model_status(pipe[4][63:32], pipe[4][31:0]);

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [3:0]  st;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   last_resp_cyc = 0;
  bit   prev_rv = 1'b0;
  bit   chk_gap = 1'b0;
  bit   gap_armed = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: handshakes push expectations, response handshakes pop and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv   = 1'b0;
      gap_armed = 1'b0;
    end else begin
      logic [N-1:0] hs;
      if (bus.req_ready != '0) begin
        check_val("ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
        check_val("ready_while_busy", 64'(busy), 64'd0);
      end
`ifdef FPU_ARB_FIXED_PRIO_EN
      if (bus.req_ready[N-1:1] != '0) check_val("fixed_upper_ready", 64'(bus.req_ready[N-1:1]), 64'd0);
`endif
      hs = bus.req_valid & bus.req_ready;
      if (hs != '0) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
          if (hs[i]) begin
            e.id   = i;
            e.data = model_data(bus.req_op_a[32*i +: 32], bus.req_op_b[32*i +: 32]);
            e.st   = model_status(bus.req_op_a[32*i +: 32], bus.req_op_b[32*i +: 32]);
            e.t    = cyc;
          end
        end
        sb.push_back(e);
        grant_log.push_back(e.id);
        $display("grant  id=%0d cycle=%0d", e.id, cyc);
        if (gap_armed) check_val("grant_gap", 64'(cyc - last_resp_cyc), 64'd1);
        gap_armed = 1'b0;
      end
      if (bus.resp_valid && !prev_rv) rise_cyc = cyc;
      prev_rv = bus.resp_valid;
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("resp   id=%0d data=0x%08h status=%0d cycle=%0d", bus.resp_id, bus.resp_data, bus.resp_status, cyc);
          check_val("resp_id", 64'(bus.resp_id), 64'(e.id));
          check_val("resp_data", 64'(bus.resp_data), 64'(e.data));
          check_val("resp_status", 64'(bus.resp_status), 64'(e.st));
          check_val("resp_latency", 64'(rise_cyc - e.t), 64'd12);
        end
        last_resp_cyc = cyc;
        if (chk_gap) gap_armed = 1'b1;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check_val({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check_val({tag, "_resp_id"}, 64'(bus.resp_id), 64'd0);
    check_val({tag, "_resp_data"}, 64'(bus.resp_data), 64'd0);
    check_val({tag, "_resp_status"}, 64'(bus.resp_status), 64'd0);
    check_val({tag, "_fpu_op_a"}, 64'(fpu_op_a), 64'd0);
    check_val({tag, "_fpu_op_b"}, 64'(fpu_op_b), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_op_a[32*i +: 32] = a;
    bus.req_op_b[32*i +: 32] = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (grant_log.size() < n) check_val("grant_timeout", 64'(grant_log.size()), 64'(n));
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) check_val("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    bus.req_valid  = '0;
    bus.req_op_a   = '0;
    bus.req_op_b   = '0;
    bus.resp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");

    // All requesters valid continuously
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    chk_gap = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'h4000_0000 + 32'(i * 32'h0011_0000), 32'h3F00_0000 + 32'(i));
    base = grant_log.size();
    wait_grants(base + 5, 200);
    @(posedge clk); #1;
    chk_gap = 1'b0;
    bus.req_valid = '0;
    wait_drain(60);
    if (grant_log.size() >= base + 5) begin
      int exp_order[5];
`ifdef FPU_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      for (int i = 0; i < 5; i++) check_val($sformatf("rr_order%0d", i), 64'(grant_log[base+i]), 64'(exp_order[i]));
    end

    // Single request from requester 1
    base = grant_log.size();
    set_req(1, 32'h4200_0000, 32'h4200_0000);
    wait_grants(base + 1, 50);
    @(posedge clk); #1 bus.req_valid = '0;
    check_val("single_op_a", 64'(fpu_op_a), 64'h4200_0000);
    check_val("single_busy", 64'(busy), 64'd1);
    wait_drain(40);

    // Operand stability: requester changes its operand during WAIT
    base = grant_log.size();
    set_req(0, 32'h3F80_0000, 32'h4000_0000);
    wait_grants(base + 1, 50);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.req_op_a[31:0] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("hold_op_a", 64'(fpu_op_a), 64'h3F80_0000);
    end
    wait_drain(40);

    // Response stall with requesters 2 and 3 waiting
    base = grant_log.size();
    bus.resp_ready = 1'b0;
    set_req(2, 32'h1234_5678, 32'h0BAD_F00D);
    set_req(3, 32'hC0DE_CAFE, 32'h0000_0001);
    wait_grants(base + 1, 50);
    begin
      int k = 0;
      while (!bus.resp_valid && k < 40) begin
        @(negedge clk);
        k++;
      end
    end
    check_val("stall_resp_seen", 64'(bus.resp_valid), 64'd1);
    chk_gap = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() != 0) begin
        check_val("stall_valid", 64'(bus.resp_valid), 64'd1);
        check_val("stall_ready", 64'(bus.req_ready), 64'd0);
        check_val("stall_id", 64'(bus.resp_id), 64'(sb[0].id));
        check_val("stall_data", 64'(bus.resp_data), 64'(sb[0].data));
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1 bus.resp_ready = 1'b1;
    wait_grants(base + 2, 20);
    @(posedge clk); #1;
    chk_gap = 1'b0;
    bus.req_valid = '0;
    wait_drain(40);
    if (grant_log.size() >= base + 2) begin
`ifdef FPU_ARB_FIXED_PRIO_EN
      check_val("stall_order1", 64'(grant_log[base+1]), 64'd2);
`else
      check_val("stall_order1", 64'(grant_log[base+1]), 64'd3);
`endif
      check_val("stall_order0", 64'(grant_log[base]), 64'd2);
    end

    // Reset pulse in the fifth WAIT cycle
    base = grant_log.size();
    set_req(0, 32'h5555_AAAA, 32'h0F0F_0F0F);
    wait_grants(base + 1, 50);
    @(posedge clk); #1 bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_val("no_resp_after_rst", 64'(bus.resp_valid), 64'd0);
    end
    @(posedge clk); #1;
    base = grant_log.size();
    set_req(2, 32'h4110_0000, 32'hC0A0_0000);
    wait_grants(base + 1, 50);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_drain(40);
    check_val("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
